// File: rtl/history_list_scroller.sv
// Cursor/window controller for scrolling record lists: edge-detected arrow keys,
// selected-row blink phase, and a row-by-row record lookup sweep for the text renderer.
module history_list_scroller #(
    parameter int DEPTH     = 32,
    parameter int ROWS      = 9,
    parameter int BLINK_DIV = 30,
    localparam int IDX_W    = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic             prog_clk,
    input  logic             rst,
    input  logic [3:0]       arrow_keys,
    input  logic [7:0]       count,
    output logic [7:0]       cursor,
    output logic [7:0]       top,
    output logic             blink_on,
    output logic             back,
    output logic             select,
    output logic [7:0]       read_record_id,
    output logic             row_wr,
    output logic [IDX_W-1:0] row_idx,
    output logic             row_empty
);

    localparam int K_W  = $clog2(ROWS + 1);
    localparam int BC_W = $clog2(BLINK_DIV);
    localparam logic [8:0]      ROWS_9  = 9'(ROWS);
    localparam logic [7:0]      ROWS_8  = 8'(ROWS);
    localparam logic [7:0]      DEPTH_8 = 8'(DEPTH);
    localparam logic [K_W-1:0]  K_LAST  = K_W'(ROWS);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(BLINK_DIV - 1);

    typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} sweep_state_e;

    logic [3:0]       keys_q;
    logic [7:0]       count_q, count_eff;
    logic [7:0]       cursor_q, cursor_d;
    logic [7:0]       top_q, top_d;
    logic             blink_q, blink_d;
    logic [BC_W-1:0]  blink_cnt_q, blink_cnt_d;
    logic             back_q, back_d;
    logic             select_q, select_d;
    sweep_state_e     state_q, state_d;
    logic [K_W-1:0]   sweep_k_q, sweep_k_d;
    logic [7:0]       addr_q, addr_d;
    logic             row_wr_q, row_wr_d;
    logic [IDX_W-1:0] row_idx_q, row_idx_d;
    logic             row_empty_q, row_empty_d;
    logic [3:0]       press;
    logic             press_one;
    logic             sweep_trig;

    // Pull the window just far enough to keep the cursor visible; an empty cursor leaves it alone.
    function automatic logic [7:0] window_top(input logic [7:0] cur, input logic [7:0] tp);
        logic [8:0] last_visible;
        last_visible = {1'b0, tp} + ROWS_9 - 9'd1;
        if (cur == 8'd0) return tp;
        if (cur < tp) return cur;
        if ({1'b0, cur} > last_visible) return 8'({1'b0, cur} - ROWS_9 + 9'd1);
        return tp;
    endfunction

    function automatic logic [7:0] row_addr(input logic [7:0] tp, input logic [K_W-1:0] k,
                                            input logic [7:0] cnt);
        logic [8:0] id;
        id = {1'b0, tp} + 9'(k);
        return (id > {1'b0, cnt}) ? 8'd0 : id[7:0];
    endfunction

    // NOTE: every variable gets a default at the top of each always_comb so no latch is inferred.
    always_comb begin
        count_eff = (count > DEPTH_8) ? DEPTH_8 : count;
        press     = arrow_keys & ~keys_q;
        press_one = (press != 4'd0) && ((press & (press - 4'd1)) == 4'd0);
        cursor_d  = cursor_q;
        top_d     = top_q;
        back_d    = 1'b0;
        select_d  = 1'b0;

        if (count_q == 8'd0 && count_eff != 8'd0) begin
            cursor_d = 8'd1;
            top_d    = 8'd1;
        end else if (cursor_d > count_eff) begin
            cursor_d = count_eff;
            top_d    = window_top(cursor_d, top_d);
        end
        if (count_eff != 8'd0 && top_d > count_eff) top_d = window_top(cursor_d, top_d);

        // Keys act on the already-adjusted count so a same-cycle count change wins.
        if (press_one) begin
            if (press[3] && count_eff != 8'd0) begin
                if (cursor_d == 8'd1) begin
                    cursor_d = count_eff;
                    top_d    = (count_eff >= ROWS_8) ? count_eff - ROWS_8 + 8'd1 : 8'd1;
                end else begin
                    cursor_d = cursor_d - 8'd1;
                    top_d    = window_top(cursor_d, top_d);
                end
            end else if (press[2] && count_eff != 8'd0) begin
                if (cursor_d == count_eff) begin
                    cursor_d = 8'd1;
                    top_d    = 8'd1;
                end else begin
                    cursor_d = cursor_d + 8'd1;
                    top_d    = window_top(cursor_d, top_d);
                end
            end else if (press[1]) begin
                back_d = 1'b1;
            end else if (press[0]) begin
                select_d = (count_eff != 8'd0);
            end
        end
    end

    always_comb begin
        blink_cnt_d = blink_cnt_q + BC_W'(1);
        blink_d     = blink_q;
        if (count_eff == 8'd0) begin
            blink_cnt_d = '0;
            blink_d     = 1'b0;
        end else if (cursor_d != cursor_q) begin
            blink_cnt_d = '0;
            blink_d     = 1'b1;
        end else if (blink_cnt_q == BC_LAST) begin
            blink_cnt_d = '0;
            blink_d     = ~blink_q;
        end
    end

    // Refresh FSM next state: sweep_k_q is the next row to address; ROWS means only the last result is left.
    always_comb begin
        sweep_trig = (top_d != top_q) || (count_eff != count_q);
        state_d    = state_q;
        sweep_k_d  = sweep_k_q;
        if (sweep_trig) begin
            state_d   = SWEEP;
            sweep_k_d = K_W'(1);
        end else if (state_q == SWEEP) begin
            if (sweep_k_q == K_LAST) begin
                state_d   = IDLE;
                sweep_k_d = '0;
            end else begin
                sweep_k_d = sweep_k_q + K_W'(1);
            end
        end
    end

    // Refresh FSM outputs: a retrigger drops the result of the old sweep's last address.
    always_comb begin
        addr_d      = cursor_d;
        row_wr_d    = 1'b0;
        row_idx_d   = row_idx_q;
        row_empty_d = 1'b0;
        if (sweep_trig) begin
            addr_d = row_addr(top_d, '0, count_eff);
        end else if (state_q == SWEEP) begin
            if (sweep_k_q != '0) begin
                row_wr_d    = 1'b1;
                row_idx_d   = IDX_W'(sweep_k_q - K_W'(1));
                row_empty_d = (addr_q == 8'd0);
            end
            if (sweep_k_q != K_LAST) addr_d = row_addr(top_q, sweep_k_q, count_q);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge prog_clk) begin
        if (rst) begin
            keys_q      <= 4'd0;
            count_q     <= 8'd0;
            cursor_q    <= 8'd0;
            top_q       <= 8'd1;
            blink_q     <= 1'b1;
            blink_cnt_q <= '0;
            back_q      <= 1'b0;
            select_q    <= 1'b0;
            state_q     <= SWEEP;
            sweep_k_q   <= '0;
            addr_q      <= 8'd0;
            row_wr_q    <= 1'b0;
            row_idx_q   <= '0;
            row_empty_q <= 1'b0;
        end else begin
            keys_q      <= arrow_keys;
            count_q     <= count_eff;
            cursor_q    <= cursor_d;
            top_q       <= top_d;
            blink_q     <= blink_d;
            blink_cnt_q <= blink_cnt_d;
            back_q      <= back_d;
            select_q    <= select_d;
            state_q     <= state_d;
            sweep_k_q   <= sweep_k_d;
            addr_q      <= addr_d;
            row_wr_q    <= row_wr_d;
            row_idx_q   <= row_idx_d;
            row_empty_q <= row_empty_d;
        end
    end

    assign cursor         = cursor_q;
    assign top            = top_q;
    assign blink_on       = blink_q;
    assign back           = back_q;
    assign select         = select_q;
    assign read_record_id = addr_q;
    assign row_wr         = row_wr_q;
    assign row_idx        = row_idx_q;
    assign row_empty      = row_empty_q;

endmodule

// File: tb/tb_history_list_scroller.sv
// Self-checking bench for history_list_scroller: directed scenarios plus random keys/counts
// compared every cycle against an integer reference model of the list rules.
module tb_history_list_scroller;

    localparam int DEPTH     = 32;
    localparam int ROWS      = 9;
    localparam int BLINK_DIV = 30;
    localparam int IDX_W     = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int OBS_W     = 8 + 8 + 1 + 1 + 1 + 8 + 1 + IDX_W + 1;

    logic             prog_clk;
    logic             rst;
    logic [3:0]       arrow_keys;
    logic [7:0]       count;
    logic [7:0]       cursor;
    logic [7:0]       top;
    logic             blink_on;
    logic             back;
    logic             select;
    logic [7:0]       read_record_id;
    logic             row_wr;
    logic [IDX_W-1:0] row_idx;
    logic             row_empty;

    int vectors;
    int miscompares;

    history_list_scroller #(.DEPTH(DEPTH), .ROWS(ROWS), .BLINK_DIV(BLINK_DIV)) dut (
        .prog_clk       (prog_clk),
        .rst            (rst),
        .arrow_keys     (arrow_keys),
        .count          (count),
        .cursor         (cursor),
        .top            (top),
        .blink_on       (blink_on),
        .back           (back),
        .select         (select),
        .read_record_id (read_record_id),
        .row_wr         (row_wr),
        .row_idx        (row_idx),
        .row_empty      (row_empty)
    );

    initial prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    // Reference model: m_age counts cycles since the current sweep was launched (-1 = pending after reset).
    logic [3:0] m_prev_keys;
    int m_cnt_prev, m_cursor, m_top, m_blink, m_bcnt, m_age;
    int m_back, m_select, m_addr, m_row_wr, m_row_idx, m_row_empty;

    function automatic int win(int cur, int tp);
        if (cur == 0) return tp;
        if (cur < tp) return cur;
        if (cur > tp + ROWS - 1) return cur - ROWS + 1;
        return tp;
    endfunction

    task automatic model_edge(input bit r, input logic [3:0] k, input logic [7:0] c);
        int ce, cur, tp;
        logic [3:0] p;
        if (r) begin
            m_prev_keys = 4'd0; m_cnt_prev = 0; m_cursor = 0; m_top = 1; m_blink = 1; m_bcnt = 0;
            m_age = -1; m_back = 0; m_select = 0; m_addr = 0; m_row_wr = 0; m_row_idx = 0; m_row_empty = 0;
            return;
        end
        ce  = (int'(c) > DEPTH) ? DEPTH : int'(c);
        cur = m_cursor;
        tp  = m_top;
        if (m_cnt_prev == 0 && ce != 0) begin
            cur = 1; tp = 1;
        end else if (cur > ce) begin
            cur = ce; tp = win(cur, tp);
        end
        if (ce != 0 && tp > ce) tp = win(cur, tp);
        p = k & ~m_prev_keys;
        m_back = 0;
        m_select = 0;
        if ($countones(p) == 1) begin
            if (p[3] && ce != 0) begin
                if (cur == 1) begin
                    cur = ce;
                    tp = (ce - ROWS + 1 > 1) ? ce - ROWS + 1 : 1;
                end else begin
                    cur = cur - 1; tp = win(cur, tp);
                end
            end else if (p[2] && ce != 0) begin
                if (cur == ce) begin
                    cur = 1; tp = 1;
                end else begin
                    cur = cur + 1; tp = win(cur, tp);
                end
            end else if (p[1]) begin
                m_back = 1;
            end else if (p[0]) begin
                m_select = (ce != 0) ? 1 : 0;
            end
        end
        if (ce == 0) begin
            m_blink = 0; m_bcnt = 0;
        end else if (cur != m_cursor) begin
            m_blink = 1; m_bcnt = 0;
        end else if (m_bcnt == BLINK_DIV - 1) begin
            m_blink = 1 - m_blink; m_bcnt = 0;
        end else begin
            m_bcnt = m_bcnt + 1;
        end
        if (tp != m_top || ce != m_cnt_prev) m_age = 0;
        else if (m_age <= ROWS) m_age = m_age + 1;
        m_row_wr = (m_age >= 1 && m_age <= ROWS) ? 1 : 0;
        m_row_idx = m_age - 1;
        m_row_empty = (m_row_wr == 1 && tp + m_age - 1 > ce) ? 1 : 0;
        m_addr = (m_age < ROWS) ? ((tp + m_age > ce) ? 0 : tp + m_age) : cur;
        m_cursor = cur;
        m_top = tp;
        m_cnt_prev = ce;
        m_prev_keys = k;
    endtask

    function automatic logic [OBS_W-1:0] dut_obs();
        return {cursor, top, blink_on, back, select, read_record_id, row_wr,
                row_wr ? row_idx : IDX_W'(0), row_wr ? row_empty : 1'b0};
    endfunction

    function automatic logic [OBS_W-1:0] model_obs();
        return {8'(m_cursor), 8'(m_top), 1'(m_blink), 1'(m_back), 1'(m_select), 8'(m_addr), 1'(m_row_wr),
                (m_row_wr != 0) ? IDX_W'(m_row_idx) : IDX_W'(0), (m_row_wr != 0) ? 1'(m_row_empty) : 1'b0};
    endfunction

    task automatic tick(input bit r, input logic [3:0] k, input logic [7:0] c);
        rst = r;
        arrow_keys = k;
        count = c;
        @(posedge prog_clk);
        model_edge(r, k, c);
        #1;
    endtask

    task automatic test_reset();
        tick(1'b1, 4'd0, 8'd12);
        tick(1'b1, 4'd0, 8'd12);
        vectors++;
        if ({cursor, top, blink_on, back, select, read_record_id, row_wr, row_idx, row_empty} !==
            {8'd0, 8'd1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, IDX_W'(0), 1'b0}) begin
            miscompares++;
            $display("FAIL reset_values: cursor=%0d top=%0d blink=%b back=%b sel=%b addr=%0d wr=%b idx=%0d empty=%b, want 0 1 1 0 0 0 0 0 0",
                     cursor, top, blink_on, back, select, read_record_id, row_wr, row_idx, row_empty);
        end
        for (int t = 1; t <= 11; t++) begin
            tick(1'b0, 4'd0, 8'd12);
            vectors++;
            if (dut_obs() !== model_obs()) begin
                miscompares++;
                $display("FAIL reset_sweep_model t=%0d: dut=%h model=%h", t, dut_obs(), model_obs());
            end
            vectors++;
            if (read_record_id !== 8'((t <= 9) ? t : 1) || row_wr !== ((t >= 2 && t <= 10) ? 1'b1 : 1'b0) ||
                (row_wr && (row_idx !== IDX_W'(t - 2) || row_empty !== 1'b0)) || cursor !== 8'd1 || top !== 8'd1) begin
                miscompares++;
                $display("FAIL reset_sweep_table t=%0d: addr=%0d wr=%b idx=%0d empty=%b cursor=%0d top=%0d",
                         t, read_record_id, row_wr, row_idx, row_empty, cursor, top);
            end
        end
    endtask

    task automatic test_down_walk();
        for (int i = 0; i < 9; i++) begin
            for (int ph = 0; ph < 2; ph++) begin
                tick(1'b0, (ph == 0) ? 4'b0100 : 4'b0000, 8'd12);
                vectors++;
                if (dut_obs() !== model_obs()) begin
                    miscompares++;
                    $display("FAIL down_walk_model i=%0d: dut=%h model=%h", i, dut_obs(), model_obs());
                end
            end
        end
        vectors++;
        if (cursor !== 8'd10 || top !== 8'd2 || read_record_id !== 8'd3 || row_wr !== 1'b1 || row_idx !== IDX_W'(0)) begin
            miscompares++;
            $display("FAIL down_walk_end: cursor=%0d top=%0d addr=%0d wr=%b idx=%0d, want 10 2 3 1 0",
                     cursor, top, read_record_id, row_wr, row_idx);
        end
        for (int i = 0; i < 60; i++) begin
            tick(1'b0, (i < 50) ? 4'b0100 : 4'b0000, 8'd12);
            vectors++;
            if (dut_obs() !== model_obs()) begin
                miscompares++;
                $display("FAIL down_hold_model i=%0d: dut=%h model=%h", i, dut_obs(), model_obs());
            end
        end
        vectors++;
        if (cursor !== 8'd11 || top !== 8'd3) begin
            miscompares++;
            $display("FAIL down_hold_single_step: cursor=%0d top=%0d, want 11 3", cursor, top);
        end
    endtask

    task automatic test_wrap();
        int writes;
        writes = 0;
        tick(1'b1, 4'd0, 8'd12);
        for (int i = 0; i < 12; i++) tick(1'b0, 4'd0, 8'd12);
        tick(1'b0, 4'b1000, 8'd12);
        vectors++;
        if (cursor !== 8'd12 || top !== 8'd4 || read_record_id !== 8'd4) begin
            miscompares++;
            $display("FAIL up_wrap: cursor=%0d top=%0d addr=%0d, want 12 4 4", cursor, top, read_record_id);
        end
        for (int i = 0; i < 11; i++) begin
            tick(1'b0, 4'd0, 8'd12);
            if (row_wr) writes++;
            vectors++;
            if (dut_obs() !== model_obs()) begin
                miscompares++;
                $display("FAIL up_wrap_sweep_model i=%0d: dut=%h model=%h", i, dut_obs(), model_obs());
            end
        end
        vectors++;
        if (writes != ROWS) begin
            miscompares++;
            $display("FAIL up_wrap_row_count: rows written=%0d, want %0d", writes, ROWS);
        end
        tick(1'b0, 4'b0100, 8'd12);
        vectors++;
        if (cursor !== 8'd1 || top !== 8'd1) begin
            miscompares++;
            $display("FAIL down_wrap: cursor=%0d top=%0d, want 1 1", cursor, top);
        end
        for (int i = 0; i < 11; i++) tick(1'b0, 4'd0, 8'd12);
    endtask

    task automatic test_short_list();
        int full, blank;
        full = 0;
        blank = 0;
        for (int i = 0; i < 11; i++) begin
            tick(1'b0, 4'd0, 8'd5);
            if (row_wr && row_empty) blank++;
            if (row_wr && !row_empty) full++;
            vectors++;
            if (dut_obs() !== model_obs()) begin
                miscompares++;
                $display("FAIL short_list_model i=%0d: dut=%h model=%h", i, dut_obs(), model_obs());
            end
        end
        vectors++;
        if (full != 5 || blank != 4) begin
            miscompares++;
            $display("FAIL short_list_rows: full=%0d blank=%0d, want 5 4", full, blank);
        end
        for (int i = 0; i < 8; i++) tick(1'b0, (i % 2 == 0) ? 4'b0100 : 4'b0000, 8'd5);
        tick(1'b0, 4'd0, 8'd3);
        vectors++;
        if (cursor !== 8'd3 || top !== 8'd1 || dut_obs() !== model_obs()) begin
            miscompares++;
            $display("FAIL count_shrink: cursor=%0d top=%0d, want 3 1 (dut=%h model=%h)",
                     cursor, top, dut_obs(), model_obs());
        end
        for (int i = 0; i < 11; i++) tick(1'b0, 4'd0, 8'd3);
    endtask

    task automatic test_empty();
        tick(1'b0, 4'd0, 8'd0);
        vectors++;
        if (cursor !== 8'd0 || blink_on !== 1'b0) begin
            miscompares++;
            $display("FAIL empty_entry: cursor=%0d blink=%b, want 0 0", cursor, blink_on);
        end
        tick(1'b0, 4'b0001, 8'd0);
        vectors++;
        if (select !== 1'b0) begin
            miscompares++;
            $display("FAIL empty_right: select=%b, want 0", select);
        end
        tick(1'b0, 4'b0000, 8'd0);
        tick(1'b0, 4'b0010, 8'd0);
        vectors++;
        if (back !== 1'b1) begin
            miscompares++;
            $display("FAIL empty_left: back=%b, want 1", back);
        end
        tick(1'b0, 4'b0010, 8'd0);
        vectors++;
        if (back !== 1'b0) begin
            miscompares++;
            $display("FAIL back_one_cycle: back=%b, want 0", back);
        end
        tick(1'b0, 4'b0000, 8'd0);
        tick(1'b0, 4'b1100, 8'd0);
        vectors++;
        if (cursor !== 8'd0 || blink_on !== 1'b0 || dut_obs() !== model_obs()) begin
            miscompares++;
            $display("FAIL empty_multi: cursor=%0d blink=%b, want 0 0", cursor, blink_on);
        end
        tick(1'b0, 4'b0000, 8'd4);
        vectors++;
        if (cursor !== 8'd1 || blink_on !== 1'b1 || top !== 8'd1) begin
            miscompares++;
            $display("FAIL empty_refill: cursor=%0d blink=%b top=%0d, want 1 1 1", cursor, blink_on, top);
        end
        tick(1'b0, 4'b0001, 8'd4);
        vectors++;
        if (select !== 1'b1) begin
            miscompares++;
            $display("FAIL right_select: select=%b, want 1", select);
        end
        tick(1'b0, 4'b0000, 8'd4);
        tick(1'b0, 4'b1100, 8'd4);
        vectors++;
        if (cursor !== 8'd1 || dut_obs() !== model_obs()) begin
            miscompares++;
            $display("FAIL multi_press_ignored: cursor=%0d, want 1", cursor);
        end
        tick(1'b0, 4'b0000, 8'd4);
    endtask

    task automatic test_blink();
        int last_toggle, toggles;
        logic prev_blink;
        last_toggle = -1;
        toggles = 0;
        prev_blink = blink_on;
        for (int t = 0; t < 75; t++) begin
            tick(1'b0, 4'd0, 8'd4);
            vectors++;
            if (dut_obs() !== model_obs()) begin
                miscompares++;
                $display("FAIL blink_model t=%0d: dut=%h model=%h", t, dut_obs(), model_obs());
            end
            if (blink_on !== prev_blink) begin
                toggles++;
                if (last_toggle >= 0) begin
                    vectors++;
                    if (t - last_toggle != BLINK_DIV) begin
                        miscompares++;
                        $display("FAIL blink_period: interval=%0d, want %0d", t - last_toggle, BLINK_DIV);
                    end
                end
                last_toggle = t;
            end
            prev_blink = blink_on;
        end
        vectors++;
        if (toggles < 2) begin
            miscompares++;
            $display("FAIL blink_toggles: seen=%0d, want >= 2", toggles);
        end
        tick(1'b0, 4'b0100, 8'd4);
        vectors++;
        if (blink_on !== 1'b1 || cursor !== 8'd2) begin
            miscompares++;
            $display("FAIL blink_restart: blink=%b cursor=%0d, want 1 2", blink_on, cursor);
        end
        for (int t = 0; t < 29; t++) begin
            tick(1'b0, 4'd0, 8'd4);
            vectors++;
            if (blink_on !== 1'b1) begin
                miscompares++;
                $display("FAIL blink_restart_hold t=%0d: blink=%b, want 1", t, blink_on);
            end
        end
    endtask

    task automatic test_mid_sweep();
        for (int i = 0; i < 5; i++) tick(1'b0, 4'd0, 8'd12);
        tick(1'b0, 4'd0, 8'd10);
        vectors++;
        if (row_wr !== 1'b0 || read_record_id !== 8'd1) begin
            miscompares++;
            $display("FAIL retrigger_suppress: wr=%b addr=%0d, want 0 1", row_wr, read_record_id);
        end
        tick(1'b0, 4'd0, 8'd10);
        vectors++;
        if (row_wr !== 1'b1 || row_idx !== IDX_W'(0) || read_record_id !== 8'd2) begin
            miscompares++;
            $display("FAIL retrigger_row0: wr=%b idx=%0d addr=%0d, want 1 0 2", row_wr, row_idx, read_record_id);
        end
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 4'd0, 8'd10);
            vectors++;
            if (dut_obs() !== model_obs()) begin
                miscompares++;
                $display("FAIL retrigger_model i=%0d: dut=%h model=%h", i, dut_obs(), model_obs());
            end
        end
        for (int i = 0; i < 4; i++) tick(1'b0, 4'd0, 8'd20);
        tick(1'b1, 4'd0, 8'd20);
        vectors++;
        if ({cursor, top, blink_on, back, select, read_record_id, row_wr, row_idx, row_empty} !==
            {8'd0, 8'd1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, IDX_W'(0), 1'b0}) begin
            miscompares++;
            $display("FAIL mid_sweep_reset: cursor=%0d top=%0d blink=%b addr=%0d wr=%b idx=%0d",
                     cursor, top, blink_on, read_record_id, row_wr, row_idx);
        end
    endtask

    task automatic test_random();
        logic [3:0] k;
        logic [7:0] c;
        bit r;
        k = 4'd0;
        c = 8'd12;
        for (int i = 0; i < 800; i++) begin
            case ($urandom_range(7))
                0, 1, 2, 3: k = 4'b0001 << $urandom_range(3);
                4, 5:       k = 4'd0;
                6:          k = 4'($urandom);
                default:    k = k;
            endcase
            if ($urandom_range(19) == 0) begin
                case ($urandom_range(3))
                    0:       c = 8'd0;
                    1:       c = 8'hff;
                    default: c = 8'($urandom_range(40));
                endcase
            end
            r = (i == 0) ? 1'b0 : ($urandom_range(199) == 0);
            tick(r, k, c);
            vectors++;
            if (dut_obs() !== model_obs()) begin
                miscompares++;
                $display("FAIL random i=%0d keys=%b count=%0d rst=%b: dut=%h model=%h",
                         i, k, c, r, dut_obs(), model_obs());
            end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        arrow_keys = 4'd0;
        count = 8'd0;
        model_edge(1'b1, 4'd0, 8'd0);
        test_reset();
        test_down_walk();
        test_wrap();
        test_short_list();
        test_empty();
        test_blink();
        test_mid_sweep();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
